reg_write_arbiter: RTL and testbench
====================================

// Module: reg_write_arbiter
// PURPOSE
//  Shares the two write ports of an 8 x 8-bit register bank among NUM_REQ requesters.
//  - Register bank: each register has dual-write DFFs, with enables reg_Write/reg_Write1.
//  - Grants up to two writes per cycle, round-robin.
//  - Never drives both ports to the same register in one cycle.
//  - Drives registered, one-hot per-register enables plus shared data.
//  - Sits between the execute/writeback requesters and the register bank.
// PARAMETERS
//  NUM_REQ   4   number of requesters
//  DATA_W    8   write data width
//  NUM_REGS  8   registers in bank
//  ADDR_W    3   register index width, clog2(NUM_REGS)
// PORTS
//  Clk        in   1                rising-edge clock
//  Rst_n      in   1                asynchronous active-low reset
//  req_valid  in   NUM_REQ          requester i has a pending write
//  req_addr   in   NUM_REQ*ADDR_W   destination index; slice i = [i*ADDR_W +: ADDR_W]
//  req_data   in   NUM_REQ*DATA_W   write data; slice i = [i*DATA_W +: DATA_W]
//  req_ready  out  NUM_REQ          write i accepted this cycle (handshake = valid & ready)
//  wr_en0     out  NUM_REGS         one-hot port-0 enables (to reg_Write of each register)
//  wr_data0   out  DATA_W           port-0 data (to in_Reg of all registers)
//  wr_en1     out  NUM_REGS         one-hot port-1 enables (to reg_Write1)
//  wr_data1   out  DATA_W           port-1 data (to in_Reg1)
//  busy       out  1                valid requests exist that were not granted this cycle
// BEHAVIOUR
//  - Reset (Rst_n=0, asynchronous):
//    - wr_en0 = wr_en1 = 0; wr_data0 = wr_data1 = 0; rr_ptr = 0.
//    - req_ready = 0 and busy = 0 while reset is held.
//  - Grant selection, combinational each cycle:
//    - Scan requesters rr_ptr, rr_ptr+1, ..., wrapping mod NUM_REQ.
//    - First valid requester found = A. It is granted to port 0.
//    - Next valid requester after A whose addr != addr(A) = B. It is granted to port 1.
//    - Valid requesters skipped for a matching addr are not granted. They stay pending, and their data/addr must be held.
//  - req_ready[i] = 1 only for A and B. Requesters must hold valid/addr/data until ready.
//  - Latency: 1 cycle. A handshake in cycle N makes wr_en/wr_data active in cycle N+1 only.
//    - wr_en0 = 1 << addr(A); wr_en1 = 1 << addr(B).
//    - An unused port drives en = 0 and data = 0.
//  - Pointer update on the clock edge:
//    - rr_ptr = (last granted index + 1) mod NUM_REQ.
//    - If nothing was granted, rr_ptr is unchanged.
//  - Invariant: wr_en0 & wr_en1 == 0 every cycle. The register bank's two-port priority is never exercised.
//  - Fairness: a continuously valid requester is granted within NUM_REQ cycles.
//  - No valid requests: outputs are 0 in the next cycle and busy = 0.
//  - Reset mid-operation:
//    - Writes already registered but not yet on the outputs are dropped.
//    - Enables fall immediately (asynchronously).
//  - busy = |(req_valid & ~req_ready), combinational.
// CONFIGURATION
//  REG_ARB_CONFLICT_CNT_EN
//  - Defined:
//    - Adds output conflict_cnt [7:0], registered, reset to 0.
//    - Increments by 1 per cycle in which at least one valid requester is deferred because its address matches A.
//    - Saturates at 8'hFF.
//  - Undefined: the port and the counter logic are absent. All other behaviour is identical.
// TESTING
//  1. Reset: hold Rst_n=0 with all req_valid=1 -> all outputs 0; release -> first grants go to req0 (port 0) and req1 (port 1).
//  2. Single write: req2 valid, addr=5, data=8'hA7 at cycle N -> req_ready[2]=1 in N; wr_en0=8'h20, wr_data0=8'hA7 in N+1; wr_en1=0.
//  3. Dual write: req0 addr=1 data=8'h11, req3 addr=6 data=8'h66 -> both ready in the same cycle; next cycle wr_en0=8'h02, wr_en1=8'h40.
//  4. Collision: req0 and req1 both addr=3 -> only req0 ready; req1 granted next cycle; wr_en1 never equals wr_en0; conflict_cnt=1 if the macro is enabled.
//  5. Round-robin: all 4 valid with distinct addrs, held -> grant pairs (0,1), (2,3), (0,1), ...; no requester waits more than 2 cycles.
//  6. Async reset mid-stream: drop Rst_n between clock edges while writes are active -> wr_en0/1 go to 0 immediately; rr_ptr=0 after release.

Source files
------------

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter sharing the two write ports of a register bank among NUM_REQ requesters.
// Optional saturating conflict counter enabled by defining REG_ARB_CONFLICT_CNT_EN.
module reg_write_arbiter #(
   parameter int NUM_REQ  = 4,
   parameter int DATA_W   = 8,
   parameter int NUM_REGS = 8,
   parameter int ADDR_W   = $clog2(NUM_REGS)
) (
   input  logic                      Clk,
   input  logic                      Rst_n,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   output logic [NUM_REQ-1:0]        req_ready,
   output logic [NUM_REGS-1:0]       wr_en0,
   output logic [DATA_W-1:0]         wr_data0,
   output logic [NUM_REGS-1:0]       wr_en1,
   output logic [DATA_W-1:0]         wr_data1,
   output logic                      busy
`ifdef REG_ARB_CONFLICT_CNT_EN
   ,
   output logic [7:0]                conflict_cnt
`endif
);

   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   function automatic logic [NUM_REGS-1:0] decode(input logic [ADDR_W-1:0] a);
      logic [NUM_REGS-1:0] r;
      r    = '0;
      r[a] = 1'b1;
      return r;
   endfunction

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] i);
      return (i == PTR_W'(NUM_REQ - 1)) ? '0 : i + 1'b1;
   endfunction

`ifdef REG_ARB_CONFLICT_CNT_EN
   function automatic logic [7:0] sat_inc(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction
`endif

   logic [PTR_W-1:0]    rr_ptr;
   logic [PTR_W-1:0]    scan_idx;
   logic [PTR_W-1:0]    a_idx;
   logic [PTR_W-1:0]    b_idx;
   logic                a_found;
   logic                b_found;
   logic                deferred;
   logic [NUM_REQ-1:0]  grant;
   logic [ADDR_W-1:0]   a_addr;
   logic [ADDR_W-1:0]   b_addr;
   logic [DATA_W-1:0]   a_data;
   logic [DATA_W-1:0]   b_data;

   // Stage p0: grant selection from the round-robin pointer
   always_comb begin
      a_found  = 1'b0;
      b_found  = 1'b0;
      a_idx    = '0;
      b_idx    = '0;
      deferred = 1'b0;
      scan_idx = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         scan_idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
         if (req_valid[scan_idx]) begin
            if (!a_found) begin
               a_found = 1'b1;
               a_idx   = scan_idx;
            end else if (req_addr[scan_idx*ADDR_W +: ADDR_W] == req_addr[a_idx*ADDR_W +: ADDR_W]) begin
               deferred = 1'b1;
            end else if (!b_found) begin
               b_found = 1'b1;
               b_idx   = scan_idx;
            end
         end
      end
   end

   always_comb begin
      grant = '0;
      if (a_found) grant[a_idx] = 1'b1;
      if (b_found) grant[b_idx] = 1'b1;
   end

   assign a_addr    = req_addr[a_idx*ADDR_W +: ADDR_W];
   assign b_addr    = req_addr[b_idx*ADDR_W +: ADDR_W];
   assign a_data    = req_data[a_idx*DATA_W +: DATA_W];
   assign b_data    = req_data[b_idx*DATA_W +: DATA_W];
   assign req_ready = grant & {NUM_REQ{Rst_n}};
   assign busy      = Rst_n & (|(req_valid & ~grant));

   logic [NUM_REGS-1:0] en0_p1;
   logic [NUM_REGS-1:0] en1_p1;
   logic [DATA_W-1:0]   data0_p1;
   logic [DATA_W-1:0]   data1_p1;

   // Stage p1: registered port drives and pointer advance
   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n) begin
         rr_ptr   <= '0;
         en0_p1   <= '0;
         en1_p1   <= '0;
         data0_p1 <= '0;
         data1_p1 <= '0;
      end else begin
         en0_p1   <= a_found ? decode(a_addr) : '0;
         data0_p1 <= a_found ? a_data : '0;
         en1_p1   <= b_found ? decode(b_addr) : '0;
         data1_p1 <= b_found ? b_data : '0;
         if (b_found)      rr_ptr <= ptr_inc(b_idx);
         else if (a_found) rr_ptr <= ptr_inc(a_idx);
      end
   end

   assign wr_en0   = en0_p1;
   assign wr_en1   = en1_p1;
   assign wr_data0 = data0_p1;
   assign wr_data1 = data1_p1;

`ifdef REG_ARB_CONFLICT_CNT_EN
   logic [7:0] cnt_p1;

   always_ff @(posedge Clk or negedge Rst_n) begin
      if (!Rst_n)        cnt_p1 <= '0;
      else if (deferred) cnt_p1 <= sat_inc(cnt_p1);
   end

   assign conflict_cnt = cnt_p1;
`endif

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Directed bench for reg_write_arbiter: reset, single/dual writes, collision, round-robin, async reset.
// Also checks conflict_cnt when built with REG_ARB_CONFLICT_CNT_EN.
module tb_reg_write_arbiter;

   logic        Clk;
   logic        Rst_n;
   logic [3:0]  req_valid;
   logic [11:0] req_addr;
   logic [31:0] req_data;
   logic [3:0]  req_ready;
   logic [7:0]  wr_en0;
   logic [7:0]  wr_data0;
   logic [7:0]  wr_en1;
   logic [7:0]  wr_data1;
   logic        busy;
`ifdef REG_ARB_CONFLICT_CNT_EN
   logic [7:0]  conflict_cnt;
`endif

   int checks   = 0;
   int failures = 0;

   reg_write_arbiter dut (
      .Clk       (Clk),
      .Rst_n     (Rst_n),
      .req_valid (req_valid),
      .req_addr  (req_addr),
      .req_data  (req_data),
      .req_ready (req_ready),
      .wr_en0    (wr_en0),
      .wr_data0  (wr_data0),
      .wr_en1    (wr_en1),
      .wr_data1  (wr_data1),
      .busy      (busy)
`ifdef REG_ARB_CONFLICT_CNT_EN
      ,
      .conflict_cnt (conflict_cnt)
`endif
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic rdy_chk(input string tag, input logic [3:0] r, input logic b);
      chk({tag, ".ready"}, 32'(req_ready), 32'(r));
      chk({tag, ".busy"}, 32'(busy), 32'(b));
   endtask

   task automatic out_chk(input string tag, input logic [7:0] e0, input logic [7:0] d0,
                          input logic [7:0] e1, input logic [7:0] d1);
      chk({tag, ".en0"}, 32'(wr_en0), 32'(e0));
      chk({tag, ".data0"}, 32'(wr_data0), 32'(d0));
      chk({tag, ".en1"}, 32'(wr_en1), 32'(e1));
      chk({tag, ".data1"}, 32'(wr_data1), 32'(d1));
      chk({tag, ".disjoint"}, 32'(wr_en0 & wr_en1), 32'd0);
   endtask

   task automatic set_req(input int i, input logic v, input logic [2:0] a, input logic [7:0] d);
      req_valid[i]       = v;
      req_addr[i*3 +: 3] = a;
      req_data[i*8 +: 8] = d;
   endtask

   task automatic all_distinct();
      for (int i = 0; i < 4; i++) set_req(i, 1'b1, 3'(i), 8'hC0 + 8'(i));
   endtask

   initial begin
      Rst_n     = 1'b0;
      req_valid = '0;
      req_addr  = '0;
      req_data  = '0;
      all_distinct();

      // Reset held with every requester valid
      repeat (2) @(posedge Clk);
      #1;
      out_chk("reset", 8'h00, 8'h00, 8'h00, 8'h00);
      rdy_chk("reset", 4'b0000, 1'b0);
`ifdef REG_ARB_CONFLICT_CNT_EN
      chk("reset.cnt", 32'(conflict_cnt), 32'd0);
`endif

      // Release: round-robin pairs (0,1), (2,3), (0,1)
      @(negedge Clk);
      Rst_n = 1'b1;
      #1 rdy_chk("rr1", 4'b0011, 1'b1);
      @(posedge Clk);
      #1 out_chk("rr1", 8'h01, 8'hC0, 8'h02, 8'hC1);
      @(negedge Clk);
      #1 rdy_chk("rr2", 4'b1100, 1'b1);
      @(posedge Clk);
      #1 out_chk("rr2", 8'h04, 8'hC2, 8'h08, 8'hC3);
      @(negedge Clk);
      #1 rdy_chk("rr3", 4'b0011, 1'b1);
      @(posedge Clk);
      #1 out_chk("rr3", 8'h01, 8'hC0, 8'h02, 8'hC1);

      // Idle cycle: outputs return to zero, pointer stays at 2
      @(negedge Clk);
      req_valid = '0;
      #1 rdy_chk("idle", 4'b0000, 1'b0);
      @(posedge Clk);
      #1 out_chk("idle", 8'h00, 8'h00, 8'h00, 8'h00);

      // Single write from req2
      @(negedge Clk);
      set_req(2, 1'b1, 3'd5, 8'hA7);
      #1 rdy_chk("single", 4'b0100, 1'b0);
      @(posedge Clk);
      #1 out_chk("single", 8'h20, 8'hA7, 8'h00, 8'h00);

      // Single write from req3 brings the pointer back to 0
      @(negedge Clk);
      req_valid = '0;
      set_req(3, 1'b1, 3'd7, 8'h5A);
      #1 rdy_chk("single3", 4'b1000, 1'b0);
      @(posedge Clk);
      #1 out_chk("single3", 8'h80, 8'h5A, 8'h00, 8'h00);

      // Dual write: req0 on port 0, req3 on port 1
      @(negedge Clk);
      req_valid = '0;
      set_req(0, 1'b1, 3'd1, 8'h11);
      set_req(3, 1'b1, 3'd6, 8'h66);
      #1 rdy_chk("dual", 4'b1001, 1'b0);
      @(posedge Clk);
      #1 out_chk("dual", 8'h02, 8'h11, 8'h40, 8'h66);

      // Collision on address 3: req1 waits one cycle
      @(negedge Clk);
      req_valid = '0;
      set_req(0, 1'b1, 3'd3, 8'h33);
      set_req(1, 1'b1, 3'd3, 8'h44);
      #1 rdy_chk("coll1", 4'b0001, 1'b1);
      @(posedge Clk);
      #1 out_chk("coll1", 8'h08, 8'h33, 8'h00, 8'h00);
`ifdef REG_ARB_CONFLICT_CNT_EN
      chk("coll1.cnt", 32'(conflict_cnt), 32'd1);
`endif
      @(negedge Clk);
      req_valid[0] = 1'b0;
      #1 rdy_chk("coll2", 4'b0010, 1'b0);
      @(posedge Clk);
      #1 out_chk("coll2", 8'h08, 8'h44, 8'h00, 8'h00);
`ifdef REG_ARB_CONFLICT_CNT_EN
      chk("coll2.cnt", 32'(conflict_cnt), 32'd1);
`endif

      // Pointer now 2; req0/req1 granted, then reset dropped mid-cycle
      @(negedge Clk);
      req_valid = '0;
      set_req(0, 1'b1, 3'd2, 8'h21);
      set_req(1, 1'b1, 3'd4, 8'h41);
      #1 rdy_chk("pre_rst", 4'b0011, 1'b0);
      @(posedge Clk);
      #1 out_chk("pre_rst", 8'h04, 8'h21, 8'h10, 8'h41);
      #2 Rst_n = 1'b0;
      #1 out_chk("async_rst", 8'h00, 8'h00, 8'h00, 8'h00);
      rdy_chk("async_rst", 4'b0000, 1'b0);
`ifdef REG_ARB_CONFLICT_CNT_EN
      chk("async_rst.cnt", 32'(conflict_cnt), 32'd0);
`endif
      all_distinct();
      @(posedge Clk);
      #1 out_chk("in_rst", 8'h00, 8'h00, 8'h00, 8'h00);

      // After release the pointer restarts at 0
      @(negedge Clk);
      Rst_n = 1'b1;
      #1 rdy_chk("post_rst", 4'b0011, 1'b1);
      @(posedge Clk);
      #1 out_chk("post_rst", 8'h01, 8'hC0, 8'h02, 8'hC1);

      @(negedge Clk);
      req_valid = '0;
      repeat (2) @(posedge Clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
